// File: rtl/pattern_detector.sv
// Receive-side checker for the "NickWantz" character stream: one-hot progress
// register, registered MATCH/ERR pulses and a wrapping completed-sequence count.
module pattern_detector #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             C_VALID,
  input  logic [0:6]       C,
  output logic [0:8]       Q,
  output logic             MATCH,
  output logic             ERR,
  output logic [CNT_W-1:0] MATCH_CNT
);

  // State encoding is the Q image itself, so Q needs no decode logic.
  typedef enum logic [8:0] {
    IDLE = 9'h000,
    S0   = 9'h100,
    S1   = 9'h080,
    S2   = 9'h040,
    S3   = 9'h020,
    S4   = 9'h010,
    S5   = 9'h008,
    S6   = 9'h004,
    S7   = 9'h002
  } state_t;

  localparam logic [6:0] CH_N = 7'h4E;

  state_t     state, state_n;
  logic       match_n, err_n;
  logic [6:0] ch, exp_ch;

  assign ch = C;
  assign Q  = state;

  always_comb begin
    exp_ch = CH_N;
    unique case (state)
      IDLE:    exp_ch = CH_N;   // 'N'
      S0:      exp_ch = 7'h69;  // 'i'
      S1:      exp_ch = 7'h63;  // 'c'
      S2:      exp_ch = 7'h6B;  // 'k'
      S3:      exp_ch = 7'h57;  // 'W'
      S4:      exp_ch = 7'h61;  // 'a'
      S5:      exp_ch = 7'h6E;  // 'n'
      S6:      exp_ch = 7'h74;  // 't'
      S7:      exp_ch = 7'h7A;  // 'z'
      default: exp_ch = CH_N;
    endcase
  end

  always_comb begin
    state_n = state;
    match_n = 1'b0;
    err_n   = 1'b0;
    if (C_VALID) begin
      if (ch == exp_ch) begin
        if (state == S7) begin
          state_n = IDLE;
          match_n = 1'b1;
        end else if (state == IDLE) begin
          state_n = S0;
        end else begin
          state_n = state_t'(state >> 1);
        end
      end else if (state != IDLE) begin
        // 'N' only occurs at index 0, so a stray 'N' is the only restart case.
        err_n   = 1'b1;
        state_n = (ch == CH_N) ? S0 : IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      MATCH     <= 1'b0;
      ERR       <= 1'b0;
      MATCH_CNT <= '0;
    end else begin
      state <= state_n;
      MATCH <= match_n;
      ERR   <= err_n;
      if (match_n) MATCH_CNT <= MATCH_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// Scoreboard bench for pattern_detector: a string-indexed reference model pushes
// expected outputs per driven cycle; each test drains and compares them.
module tb_pattern_detector;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       C_VALID = 1'b0;
  logic [0:6] C = '0;
  logic [0:8] q8, q2;
  logic       m8, e8, m2, e2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 CLK = ~CLK;

  pattern_detector #(.CNT_W(8)) u8 (
    .CLK(CLK), .RST(RST), .C_VALID(C_VALID), .C(C),
    .Q(q8), .MATCH(m8), .ERR(e8), .MATCH_CNT(cnt8)
  );

  pattern_detector #(.CNT_W(2)) u2 (
    .CLK(CLK), .RST(RST), .C_VALID(C_VALID), .C(C),
    .Q(q2), .MATCH(m2), .ERR(e2), .MATCH_CNT(cnt2)
  );

  typedef struct {
    logic [0:8] q;
    logic       m;
    logic       e;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [0:8] q2;
    logic       m2;
    logic       e2;
  } rec_t;

  rec_t  exp_q[$];
  rec_t  obs_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    midx  = -1;   // -1 = idle, k = character k last accepted
  int    mcnt  = 0;
  string SEQ   = "NickWantz";

  // Drive one cycle, predict the result, then capture what the DUT shows.
  task automatic step(input logic rst, input logic v, input logic [7:0] ch);
    rec_t x, o;
    logic m, e;
    byte  want;
    RST = rst; C_VALID = v; C = ch[6:0];
    m = 1'b0; e = 1'b0;
    if (rst) begin
      midx = -1; mcnt = 0;
    end else if (v) begin
      want = SEQ[midx + 1];
      if (ch[6:0] == want[6:0]) begin
        if (midx == 7) begin midx = -1; m = 1'b1; mcnt++; end
        else midx++;
      end else if (midx != -1) begin
        e = 1'b1;
        midx = (ch[6:0] == 7'h4E) ? 0 : -1;
      end
    end
    x.q = '0;
    if (midx >= 0) x.q[midx] = 1'b1;
    x.m = m; x.e = e;
    x.cnt = mcnt[7:0]; x.cnt2 = mcnt[1:0];
    x.q2 = x.q; x.m2 = m; x.e2 = e;
    exp_q.push_back(x);
    @(posedge CLK); #1;
    o.q = q8; o.m = m8; o.e = e8; o.cnt = cnt8; o.cnt2 = cnt2;
    o.q2 = q2; o.m2 = m2; o.e2 = e2;
    obs_q.push_back(o);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
  endtask

  task automatic test_reset;
    rec_t x, o;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, "N");
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL reset: got q=%b m=%b e=%b cnt=%0d cnt2=%0d, want q=%b m=%b e=%b cnt=%0d cnt2=%0d",
                 o.q, o.m, o.e, o.cnt, o.cnt2, x.q, x.m, x.e, x.cnt, x.cnt2);
      end
    end
  endtask

  task automatic test_back_to_back;
    rec_t x, o;
    send("NickWantzNickWantz");
    step(1'b0, 1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL back_to_back: got q=%b m=%b e=%b cnt=%0d cnt2=%0d, want q=%b m=%b e=%b cnt=%0d cnt2=%0d",
                 o.q, o.m, o.e, o.cnt, o.cnt2, x.q, x.m, x.e, x.cnt, x.cnt2);
      end
    end
    n_cmp++;
    if (cnt8 !== 8'd2) begin
      n_bad++;
      $display("FAIL back_to_back_count: got %0d want 2", cnt8);
    end
  endtask

  task automatic test_break;
    rec_t x, o;
    step(1'b1, 1'b0, 8'h00);
    send("NicXNickWantz");
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL break: got q=%b m=%b e=%b cnt=%0d cnt2=%0d, want q=%b m=%b e=%b cnt=%0d cnt2=%0d",
                 o.q, o.m, o.e, o.cnt, o.cnt2, x.q, x.m, x.e, x.cnt, x.cnt2);
      end
    end
  endtask

  task automatic test_restart;
    rec_t x, o;
    step(1'b1, 1'b0, 8'h00);
    send("NickNickWantz");
    send("nNz");   // 'n' idle, 'z' breaks S0 with no restart
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL restart: got q=%b m=%b e=%b cnt=%0d cnt2=%0d, want q=%b m=%b e=%b cnt=%0d cnt2=%0d",
                 o.q, o.m, o.e, o.cnt, o.cnt2, x.q, x.m, x.e, x.cnt, x.cnt2);
      end
    end
  endtask

  task automatic test_gap;
    rec_t x, o;
    send("Nick");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'hxx);
    send("Wantz");
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL gap: got q=%b m=%b e=%b cnt=%0d cnt2=%0d, want q=%b m=%b e=%b cnt=%0d cnt2=%0d",
                 o.q, o.m, o.e, o.cnt, o.cnt2, x.q, x.m, x.e, x.cnt, x.cnt2);
      end
    end
  endtask

  task automatic test_midreset;
    rec_t x, o;
    send("NickWan");
    step(1'b1, 1'b1, "t");
    send("tzn");
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL midreset: got q=%b m=%b e=%b cnt=%0d cnt2=%0d, want q=%b m=%b e=%b cnt=%0d cnt2=%0d",
                 o.q, o.m, o.e, o.cnt, o.cnt2, x.q, x.m, x.e, x.cnt, x.cnt2);
      end
    end
  endtask

  task automatic test_wrap;
    rec_t x, o;
    logic [1:0] seen[5];
    logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    step(1'b1, 1'b0, 8'h00);
    for (int s = 0; s < 5; s++) begin
      send("NickWantz");
      seen[s] = cnt2;
    end
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL wrap: got q=%b m=%b e=%b cnt=%0d cnt2=%0d, want q=%b m=%b e=%b cnt=%0d cnt2=%0d",
                 o.q, o.m, o.e, o.cnt, o.cnt2, x.q, x.m, x.e, x.cnt, x.cnt2);
      end
    end
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if (seen[s] !== want[s]) begin
        n_bad++;
        $display("FAIL wrap_cnt%0d: got %0d want %0d", s, seen[s], want[s]);
      end
    end
  endtask

  initial begin
    @(posedge CLK); #1;
    test_reset;
    test_back_to_back;
    test_break;
    test_restart;
    test_gap;
    test_midreset;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Receive-side counterpart of the one-hot ring pattern generator and its character coder. Accepts a stream of 7-bit ASCII characters and tracks progress through the fixed 9-character sequence "NickWantz" with a 9-bit one-hot state register. Pulses `MATCH` on each complete sequence and `ERR` when a partial sequence breaks. Sits downstream of the generator or any character source, and is used to check generator output in-system.

## Interface
- `CNT_W`, default 8: width of the completed-sequence counter.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `C_VALID` in 1: `C` carries a character this cycle.
- `C` in [0:6]: character, `C[0]` = MSB (ASCII bit 6).
- `Q` out [0:8]: one-hot progress. `Q[k]`=1 means character k of the sequence was the last accepted. All-zero means idle.
- `MATCH` out 1: one-cycle pulse on sequence completion.
- `ERR` out 1: one-cycle pulse when an in-progress sequence is broken.
- `MATCH_CNT` out `CNT_W`: number of completed sequences, wraps.

## Operation
- Sequence, index 0..8, as `C[0:6]`:
  - 0: 'N' 1001110
  - 1: 'i' 1101001
  - 2: 'c' 1100011
  - 3: 'k' 1101011
  - 4: 'W' 1010111
  - 5: 'a' 1100001
  - 6: 'n' 1101110
  - 7: 't' 1110100
  - 8: 'z' 1111010
- States: IDLE (`Q`=0), S0..S7 (`Q[k]`=1). `Q[8]` is never held; completion returns to IDLE.
- Expected character: index 0 in IDLE, index k+1 in Sk.
- Transitions happen only on cycles with `C_VALID`=1. With `C_VALID`=0: `Q` holds, `MATCH`=0, `ERR`=0.
- Expected char, state IDLE or S0..S6: advance to the next state. `MATCH`=0, `ERR`=0.
- Expected char 'z' in S7: go to IDLE, `MATCH`=1, `MATCH_CNT` += 1.
- Unexpected char that is 'N', in any state except IDLE: go to S0 (restart), `ERR`=1.
- Unexpected char that is not 'N', in any state except IDLE: go to IDLE, `ERR`=1.
- In IDLE, any char other than 'N': stay IDLE, `ERR`=0. Garbage between sequences is not an error.
- 'N' appears only at index 0, so no other overlap or prefix-fallback cases exist.
- Case matters: 'n' (1101110) is never equal to 'N'.
- `MATCH_CNT` wraps from 2^`CNT_W`-1 to 0 with no flag.
- `X`/`Z` on `C` while `C_VALID`=0 must not affect state.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- Latency: a character sampled at rising edge n is reflected in `Q`, `MATCH`, `ERR` and `MATCH_CNT` immediately after edge n, and is visible during cycle n+1.
- `MATCH` and `ERR` are high for exactly one cycle per event. They are never high in the same cycle.
- Back-to-back sequences with `C_VALID` held high (generator free-running): 'z' then 'N' produces `MATCH`=1 while `Q` goes to 0. The next edge gives `Q[0]`=1. No cycle is lost.
- Reset values, applied at the edge where `RST`=1: `Q`=0, `MATCH`=0, `ERR`=0, `MATCH_CNT`=0.
- `RST` overrides `C_VALID` in the same cycle.
- Reset mid-sequence discards progress and raises no `ERR`.

## Test plan
- Continuous stream "NickWantzNickWantz" with `C_VALID`=1 and `RST` deasserted after 2 cycles -> `Q` walks 100000000, 010000000 … 000000010, then 0. `MATCH` pulses at cycles 10 and 19. `MATCH_CNT`=2. `ERR` never asserts.
- "NicX" then "NickWantz" -> `ERR`=1 for one cycle after 'X' (0x58) with `Q`=0. The full sequence then gives `MATCH`=1 and `MATCH_CNT`=1.
- "NickN" then "ickWantz" -> `ERR`=1 after the second 'N' with `Q`=100000000. `MATCH` follows 'z'. `MATCH_CNT`=1.
- "Nick" with `C_VALID`=0 for 5 cycles, then "Wantz" -> `Q` holds 000100000 throughout the gap. `MATCH`=1 after 'z'.
- "NickWan", then `RST`=1 for 1 cycle while `C_VALID`=1, then "tz" -> all outputs are 0 after reset, no `MATCH` and no `ERR`. Also: 'n' in IDLE leaves `Q`=0.
- `CNT_W`=2, five complete sequences -> `MATCH_CNT` goes 1, 2, 3, 0, 1.
